// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: frame FSM states and widths.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of a bit
// and the cycle before it, and is held at zero while restart is high.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // Reload on bit boundaries so the count never wraps through an unused code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (restart || bit_end) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

  assign bit_end = (cnt == LAST);
  assign pre_end = (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO whenever it is
// non-empty; all serial/handshake outputs come straight from flops.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_emp,
  input  logic [DATA_W-1:0] fifo_read_data,
  output logic              fifo_read_req,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        idx;
  logic              restart;
  logic              bit_end;
  logic              pre_end;

  // Timer is parked at zero outside the timed states, so START always
  // begins a fresh bit period.
  assign restart = (state == IDLE) || (state == REQ) || (state == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .bit_end (bit_end),
    .pre_end (pre_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      idx           <= '0;
      tx            <= 1'b1;
      fifo_read_req <= 1'b0;
      busy          <= 1'b0;
      byte_done     <= 1'b0;
    end else begin
      fifo_read_req <= 1'b0;
      byte_done     <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!fifo_emp) begin
            state         <= REQ;
            fifo_read_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          // FIFO data is valid the cycle after the pop strobe.
          shreg <= fifo_read_data;
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
              tx  <= shreg[1];
            end
          end
        end
        STOP: begin
          // Registered one cycle early so the pulse lands on the last stop cycle.
          byte_done <= pre_end;
          if (bit_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_param
      $error("fifo_uart_tx: CLKS_PER_BIT out of range");
    end
  endgenerate

  a_req_single: assert property (@(posedge clk) disable iff (reset)
    fifo_read_req |=> !fifo_read_req);

  a_req_only_in_req: assert property (@(posedge clk) disable iff (reset)
    fifo_read_req |-> (state == REQ));

  a_done_in_stop: assert property (@(posedge clk) disable iff (reset)
    byte_done |-> (state == STOP));

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at CLKS_PER_BIT=4: frame-level reference model,
// table-driven directed frames, reset/idle corner cases and random traffic.
module tb_fifo_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 2 + 10 * C;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_emp;
  logic [7:0] fifo_read_data;
  logic       fifo_read_req;
  logic       tx;
  logic       busy;
  logic       byte_done;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_emp       (fifo_emp),
    .fifo_read_data (fifo_read_data),
    .fifo_read_req  (fifo_read_req),
    .tx             (tx),
    .busy           (busy),
    .byte_done      (byte_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a frame is FRAME cycles long counted from the pop strobe
  // (k=0 strobe, k=1 load, then ten bit periods); one idle cycle after it.
  bit         m_on = 1'b0;
  int         m_k  = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] byte_q[$];

  logic tx_log [0:65535];
  int   req_cnt   = 0;
  int   done_cnt  = 0;
  int   last_req  = 0;
  int   last_done = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = i-th serial bit on the line
    bit         toggle;  // wiggle fifo_emp every cycle during the frame
  } vec_t;

  vec_t vecs[4];

  function automatic logic m_tx();
    int b;
    if (!m_on || m_k < 2) return 1'b1;
    b = (m_k - 2) / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input logic emp, input logic rst);
    fifo_emp       = emp;
    reset          = rst;
    fifo_read_data = (m_on && m_k == 1) ? m_byte : 8'($urandom);
    @(posedge clk);
    if (reset) m_on = 1'b0;
    else if (m_on) begin
      m_k++;
      if (m_k == FRAME) m_on = 1'b0;
    end else if (!fifo_emp) begin
      m_on   = 1'b1;
      m_k    = 0;
      m_byte = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
    end
    @(negedge clk);
    cyc++;
    if (cyc < 65536) tx_log[cyc] = tx;
    if (fifo_read_req) begin req_cnt++;  last_req  = cyc; end
    if (byte_done)     begin done_cnt++; last_done = cyc; end
    chk($sformatf("model cyc %0d {tx,req,busy,done}", cyc),
        {28'd0, tx, fifo_read_req, busy, byte_done},
        {28'd0, m_tx(), (m_on && m_k == 0), m_on, (m_on && m_k == FRAME - 1)});
  endtask

  task automatic check_frame(input int r, input logic [9:0] f, input string name);
    logic [C-1:0] g;
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < C; j++) g[j] = tx_log[r + 2 + b * C + j];
      chk($sformatf("%s bit %0d", name, b), {{(32-C){1'b0}}, g},
          f[b] ? {{(32-C){1'b0}}, {C{1'b1}}} : 32'd0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int  r0 = req_cnt;
    int  d0 = done_cnt;
    bit  seen = 1'b0;
    bit  tg = 1'b1;
    string nm = $sformatf("frame %02h", v.data);
    byte_q.push_back(v.data);
    tick(1'b0, 1'b0);
    for (int i = 0; i < FRAME + 10 && !seen; i++) begin
      tick(v.toggle ? tg : 1'b1, 1'b0);
      tg = ~tg;
      if (done_cnt != d0) seen = 1'b1;
    end
    chk({nm, " done seen"}, {31'd0, seen}, 32'd1);
    chk({nm, " strobes"}, req_cnt - r0, 32'd1);
    chk({nm, " strobe to done"}, last_done - last_req, FRAME - 1);
    check_frame(last_req, v.frame, nm);
    repeat (3) tick(1'b1, 1'b0);
  endtask

  initial begin
    int r0, d0, r1, rr;
    bit tx_low, busy_hi;

    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, toggle: 1'b0};
    vecs[1] = '{data: 8'h01, frame: 10'b1000000010, toggle: 1'b0};
    vecs[2] = '{data: 8'h80, frame: 10'b1100000000, toggle: 1'b1};
    vecs[3] = '{data: 8'h5A, frame: 10'b1010110100, toggle: 1'b1};

    reset          = 1'b1;
    fifo_emp       = 1'b0;
    fifo_read_data = 8'h00;

    // Reset held with a non-empty FIFO: nothing may move.
    repeat (8) tick(1'b0, 1'b1);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset req", {31'd0, fifo_read_req}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, byte_done}, 32'd0);
    chk("reset strobes", req_cnt, 32'd0);
    repeat (3) tick(1'b1, 1'b0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Back-to-back 0x00 then 0xFF with the FIFO never empty.
    byte_q.push_back(8'h00);
    byte_q.push_back(8'hFF);
    r0 = req_cnt; d0 = done_cnt; r1 = -1;
    for (int i = 0; i < 3 * FRAME && (req_cnt - r0) < 2; i++) begin
      tick(1'b0, 1'b0);
      if (r1 < 0 && (req_cnt - r0) == 1) r1 = last_req;
    end
    for (int i = 0; i < FRAME + 10 && (done_cnt - d0) < 2; i++) tick(1'b1, 1'b0);
    chk("b2b strobes", req_cnt - r0, 32'd2);
    chk("b2b dones", done_cnt - d0, 32'd2);
    chk("b2b strobe spacing", last_req - r1, FRAME + 1);
    check_frame(r1, 10'b1000000000, "b2b 00");
    check_frame(last_req, 10'b1111111110, "b2b FF");
    repeat (3) tick(1'b1, 1'b0);

    // Empty FIFO for 200 cycles.
    r0 = req_cnt; tx_low = 1'b0; busy_hi = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b1, 1'b0);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (busy !== 1'b0) busy_hi = 1'b1;
    end
    chk("idle strobes", req_cnt - r0, 32'd0);
    chk("idle tx low seen", {31'd0, tx_low}, 32'd0);
    chk("idle busy seen", {31'd0, busy_hi}, 32'd0);

    // Reset in the middle of data bit 3 of 0x3C.
    byte_q.push_back(8'h3C);
    r0 = req_cnt;
    tick(1'b0, 1'b0);
    rr = last_req;
    for (int i = 0; i < 40 && cyc < rr + 2 + 4 * C + 1; i++) tick(1'b1, 1'b0);
    chk("3C strobe", req_cnt - r0, 32'd1);
    chk("3C busy before reset", {31'd0, busy}, 32'd1);
    d0 = done_cnt; r0 = req_cnt;
    reset = 1'b1;
    #1;
    chk("mid-frame reset tx", {31'd0, tx}, 32'd1);
    chk("mid-frame reset busy", {31'd0, busy}, 32'd0);
    repeat (2) tick(1'b1, 1'b1);
    repeat (60) tick(1'b1, 1'b0);
    chk("abandoned byte done", done_cnt - d0, 32'd0);
    chk("post-reset strobes", req_cnt - r0, 32'd0);

    // Random traffic against the model, with rare resets.
    for (int blk = 0; blk < 40; blk++) begin
      int dens = $urandom_range(0, 3);
      for (int i = 0; i < 100; i++)
        tick(($urandom_range(0, 3) < dens) ? 1'b0 : 1'b1, ($urandom_range(0, 499) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
